tail_light_ctrl: RTL and testbench

Sequencing controller for the six-lamp tail-light datapath (left lamps La/Lb/Lc, right lamps Ra/Rb/Rc). It arbitrates between the left-turn, right-turn, hazard and brake requests and steps the lamp patterns at a programmable animation rate. It sits between the driver switch inputs and the lamp drivers, and replaces free-running per-clock stepping with a prescaled, priority-resolved sequence.

---
 rtl/tail_light_ctrl_if.sv | 17 +
 rtl/tail_light_ctrl.sv | 102 ++++++++++
 tb/tb_tail_light_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/tail_light_ctrl_if.sv
// Request and lamp bundle between the switch inputs and the tail-light sequencer.
interface tail_light_ctrl_if;
    logic L;
    logic R;
    logic H;
    logic B;
    logic La;
    logic Lb;
    logic Lc;
    logic Ra;
    logic Rb;
    logic Rc;
    logic busy;

    modport master (output L, R, H, B, input La, Lb, Lc, Ra, Rb, Rc, busy);
    modport slave  (input L, R, H, B, output La, Lb, Lc, Ra, Rb, Rc, busy);
endinterface

// File: rtl/tail_light_ctrl.sv
// Tail-light sequencer: prioritised turn/hazard/brake arbitration with prescaled lamp stepping.
// Optional macro TAIL_LIGHT_CANCEL_EN: an opposite-side request aborts a running sweep.
module tail_light_ctrl #(
    parameter int TICK_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    tail_light_ctrl_if.slave   lamps
);

    // state | meaning
    // IDLE  | arbitrating, lamps show brake only     L1..L3 / R1..R3 | sweep step 1..3
    // HAZ_ON / HAZ_OFF | hazard flash phases, brake ignored
    localparam logic [3:0] IDLE    = 4'd0;
    localparam logic [3:0] L1      = 4'd1;
    localparam logic [3:0] L2      = 4'd2;
    localparam logic [3:0] L3      = 4'd3;
    localparam logic [3:0] R1      = 4'd4;
    localparam logic [3:0] R2      = 4'd5;
    localparam logic [3:0] R3      = 4'd6;
    localparam logic [3:0] HAZ_ON  = 4'd7;
    localparam logic [3:0] HAZ_OFF = 4'd8;

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [3:0]    state;
    logic [3:0]    state_nx;
    logic [CW-1:0] cnt;
    logic          b_q;
    logic          tick;
    logic [2:0]    left_on;
    logic [2:0]    right_on;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (lamps.H || (lamps.L && lamps.R)) state_nx = HAZ_ON;
                else if (lamps.L)                    state_nx = L1;
                else if (lamps.R)                    state_nx = R1;
            end
            L1, L2, L3: begin
                if (lamps.H) state_nx = HAZ_ON;
`ifdef TAIL_LIGHT_CANCEL_EN
                else if (lamps.R && !lamps.L) state_nx = IDLE;
`endif
                else if (tick) state_nx = (state == L1) ? L2 : (state == L2) ? L3 : IDLE;
            end
            R1, R2, R3: begin
                if (lamps.H) state_nx = HAZ_ON;
`ifdef TAIL_LIGHT_CANCEL_EN
                else if (lamps.L && !lamps.R) state_nx = IDLE;
`endif
                else if (tick) state_nx = (state == R1) ? R2 : (state == R2) ? R3 : IDLE;
            end
            HAZ_ON:  if (tick) state_nx = HAZ_OFF;
            HAZ_OFF: if (tick) state_nx = lamps.H ? HAZ_ON : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Counter restarts on every state change; IDLE holds it at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            b_q   <= 1'b0;
        end else begin
            state <= state_nx;
            b_q   <= lamps.B;
            if (state_nx != state || state_nx == IDLE) cnt <= '0;
            else                                       cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        left_on  = 3'b000;
        right_on = 3'b000;
        case (state)
            IDLE:    begin left_on = {3{b_q}}; right_on = {3{b_q}}; end
            L1:      begin left_on = 3'b001;   right_on = {3{b_q}}; end
            L2:      begin left_on = 3'b011;   right_on = {3{b_q}}; end
            L3:      begin left_on = 3'b111;   right_on = {3{b_q}}; end
            R1:      begin left_on = {3{b_q}}; right_on = 3'b001;   end
            R2:      begin left_on = {3{b_q}}; right_on = 3'b011;   end
            R3:      begin left_on = {3{b_q}}; right_on = 3'b111;   end
            HAZ_ON:  begin left_on = 3'b111;   right_on = 3'b111;   end
            default: begin left_on = 3'b000;   right_on = 3'b000;   end
        endcase
    end

    assign lamps.La   = left_on[0];
    assign lamps.Lb   = left_on[1];
    assign lamps.Lc   = left_on[2];
    assign lamps.Ra   = right_on[0];
    assign lamps.Rb   = right_on[1];
    assign lamps.Rc   = right_on[2];
    assign lamps.busy = (state != IDLE);

endmodule

// File: tb/tb_tail_light_ctrl.sv
// Bench for tail_light_ctrl: directed vector table followed by random requests against a timeline model.
module tb_tail_light_ctrl;
    localparam int TD = 4;

    typedef struct {
        logic       rst;
        logic       l;
        logic       r;
        logic       h;
        logic       b;
        int         n;
        logic [5:0] lamps;
        logic       busy;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   errors = 0;

    // Model: active sequence kind and cycles elapsed since it started.
    int   m_mode = 0;  // 0 idle, 1 left, 2 right, 3 hazard
    int   m_age  = 0;
    bit   m_bq   = 1'b0;

    vec_t vecs[$];

    tail_light_ctrl_if bus ();

    tail_light_ctrl #(.TICK_DIV(TD)) dut (
        .clk   (clk),
        .reset (reset),
        .lamps (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] model_lamps();
        int n;
        logic [2:0] sw;
        n  = m_age / TD + 1;
        sw = {1'b1, n >= 2, n >= 3};
        case (m_mode)
            1:       return {sw, {3{m_bq}}};
            2:       return {{3{m_bq}}, sw};
            3:       return (m_age < TD) ? 6'b111111 : 6'b000000;
            default: return {6{m_bq}};
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit l, input bit r, input bit h, input bit b);
        if (rst) begin
            m_mode = 0; m_age = 0; m_bq = 1'b0;
        end else begin
            case (m_mode)
                0: begin
                    m_age = 0;
                    if (h || (l && r)) m_mode = 3;
                    else if (l)        m_mode = 1;
                    else if (r)        m_mode = 2;
                end
                1, 2: begin
                    if (h) begin
                        m_mode = 3; m_age = 0;
                    end
`ifdef TAIL_LIGHT_CANCEL_EN
                    else if ((m_mode == 1 && r && !l) || (m_mode == 2 && l && !r)) begin
                        m_mode = 0; m_age = 0;
                    end
`endif
                    else if (m_age == 3 * TD - 1) begin
                        m_mode = 0; m_age = 0;
                    end else m_age++;
                end
                default: begin
                    if (m_age == 2 * TD - 1) begin
                        m_age = 0;
                        if (!h) m_mode = 0;
                    end else m_age++;
                end
            endcase
            m_bq = b;
        end
    endtask

    task automatic cycle(input bit rst, input bit l, input bit r, input bit h, input bit b);
        reset = rst; bus.L = l; bus.R = r; bus.H = h; bus.B = b;
        @(posedge clk);
        model_step(rst, l, r, h, b);
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [5:0] exp_lamps, input logic exp_busy);
        logic [5:0] got;
        got = {bus.La, bus.Lb, bus.Lc, bus.Ra, bus.Rb, bus.Rc};
        tests++;
        if (got !== exp_lamps || bus.busy !== exp_busy) begin
            errors++;
            $display("FAIL %s @%0t: got lamps=%b busy=%b, expected lamps=%b busy=%b",
                     nm, $time, got, bus.busy, exp_lamps, exp_busy);
        end
    endtask

    function automatic void add(input bit rst, input bit l, input bit r, input bit h, input bit b,
                                input int n, input logic [5:0] lamps, input logic busy,
                                input string name);
        vec_t v;
        v.rst = rst; v.l = l; v.r = r; v.h = h; v.b = b;
        v.n = n; v.lamps = lamps; v.busy = busy; v.name = name;
        vecs.push_back(v);
    endfunction

    initial begin
        // lamp order: La Lb Lc Ra Rb Rc
        add(1, 1, 1, 1, 1, 2, 6'b000000, 0, "reset_hold");
        add(0, 1, 1, 1, 1, 1, 6'b111111, 1, "reset_release_haz");
        add(0, 0, 0, 0, 0, 3, 6'b111111, 1, "haz_on_rest");
        add(0, 0, 0, 0, 0, 4, 6'b000000, 1, "haz_off");
        add(0, 0, 0, 0, 0, 1, 6'b000000, 0, "haz_idle");
        // left sweep from a one-cycle pulse
        add(0, 1, 0, 0, 0, 1, 6'b100000, 1, "left_l1_start");
        add(0, 0, 0, 0, 0, 3, 6'b100000, 1, "left_l1");
        add(0, 0, 0, 0, 0, 4, 6'b110000, 1, "left_l2");
        add(0, 0, 0, 0, 0, 4, 6'b111000, 1, "left_l3");
        add(0, 0, 0, 0, 0, 1, 6'b000000, 0, "left_done");
        // simultaneous L and R
        add(0, 1, 1, 0, 0, 1, 6'b111111, 1, "lr_haz");
        add(0, 0, 0, 0, 0, 3, 6'b111111, 1, "lr_haz_on");
        add(0, 0, 0, 0, 0, 4, 6'b000000, 1, "lr_haz_off");
        add(0, 0, 0, 0, 0, 1, 6'b000000, 0, "lr_idle");
        // brake in idle
        add(0, 0, 0, 0, 1, 1, 6'b111111, 0, "brake_idle");
        add(0, 0, 0, 0, 0, 1, 6'b000000, 0, "brake_idle_off");
        // brake during right sweep
        add(0, 0, 1, 0, 0, 1, 6'b000100, 1, "right_r1_start");
        add(0, 0, 0, 0, 1, 3, 6'b111100, 1, "right_r1_brake");
        add(0, 0, 0, 0, 1, 2, 6'b111110, 1, "right_r2_brake");
        add(0, 0, 0, 0, 0, 2, 6'b000110, 1, "right_r2");
        add(0, 0, 0, 0, 0, 4, 6'b000111, 1, "right_r3");
        add(0, 0, 0, 0, 0, 1, 6'b000000, 0, "right_done");
        // hazard preempts L2, repeats, then drops mid HAZ_ON
        add(0, 1, 0, 0, 0, 1, 6'b100000, 1, "pre_l1_start");
        add(0, 0, 0, 0, 0, 3, 6'b100000, 1, "pre_l1");
        add(0, 0, 0, 0, 0, 2, 6'b110000, 1, "pre_l2");
        add(0, 0, 0, 1, 0, 1, 6'b111111, 1, "pre_haz_enter");
        add(0, 0, 0, 1, 0, 3, 6'b111111, 1, "pre_haz_on");
        add(0, 0, 0, 1, 0, 4, 6'b000000, 1, "pre_haz_off");
        add(0, 0, 0, 1, 0, 2, 6'b111111, 1, "pre_haz_on2");
        add(0, 0, 0, 0, 0, 2, 6'b111111, 1, "pre_haz_on2_drop");
        add(0, 0, 0, 0, 0, 4, 6'b000000, 1, "pre_haz_off2");
        add(0, 0, 0, 0, 0, 1, 6'b000000, 0, "pre_idle");
        // opposite-side request during L2
        add(0, 1, 0, 0, 0, 1, 6'b100000, 1, "opp_l1_start");
        add(0, 0, 0, 0, 0, 3, 6'b100000, 1, "opp_l1");
        add(0, 0, 0, 0, 0, 1, 6'b110000, 1, "opp_l2");
`ifdef TAIL_LIGHT_CANCEL_EN
        add(0, 0, 1, 0, 0, 1, 6'b000000, 0, "cancel_idle");
        add(0, 0, 1, 0, 0, 1, 6'b000100, 1, "cancel_r1");
        add(0, 0, 0, 0, 0, 3, 6'b000100, 1, "cancel_r1_rest");
        add(0, 0, 0, 0, 0, 4, 6'b000110, 1, "cancel_r2");
        add(0, 0, 0, 0, 0, 4, 6'b000111, 1, "cancel_r3");
        add(0, 0, 0, 0, 0, 1, 6'b000000, 0, "cancel_done");
`else
        add(0, 0, 1, 0, 0, 2, 6'b110000, 1, "opp_ignored");
        add(0, 0, 0, 0, 0, 1, 6'b110000, 1, "opp_l2_rest");
        add(0, 0, 0, 0, 0, 4, 6'b111000, 1, "opp_l3");
        add(0, 0, 0, 0, 0, 1, 6'b000000, 0, "opp_done");
`endif

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                cycle(vecs[i].rst, vecs[i].l, vecs[i].r, vecs[i].h, vecs[i].b);
                chk(vecs[i].name, vecs[i].lamps, vecs[i].busy);
            end
        end

        cycle(1, 0, 0, 0, 0);
        chk("rand_reset", model_lamps(), 1'b0);
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 3) == 0);
            chk("random", model_lamps(), m_mode != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
